median3x3_stream_filter: RTL and testbench



---
 rtl/median3x3_stream_filter.sv | 146 ++++++++++++++
 tb/tb_median3x3_stream_filter.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/median3x3_stream_filter.sv
// median3x3_stream_filter: streaming 3x3 per-channel median over raster RGB video,
// with selectable border policy, output backpressure and fill/flush framing.
module median3x3_stream_filter #(
  parameter int IMAGE_LEN    = 1080,
  parameter int IMAGE_HEIGHT = 720,
  parameter int PIXEL_W      = 8,
  parameter int NUM_CH       = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start_i,
  input  logic                      border_mode_i,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic [NUM_CH*PIXEL_W-1:0] in_pixel_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [NUM_CH*PIXEL_W-1:0] out_pixel_o,
  output logic                      busy_o,
  output logic                      done_o
);
  localparam int PW  = NUM_CH * PIXEL_W;
  localparam int TOT = IMAGE_LEN * IMAGE_HEIGHT;
  localparam int CW  = $clog2(TOT + IMAGE_LEN + 2);
  localparam int XW  = $clog2(IMAGE_LEN);
  localparam int YW  = $clog2(IMAGE_HEIGHT);

  typedef enum logic [2:0] {IDLE, FILL, RUN, FLUSH, DONE} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q;
  logic [XW-1:0]     col_q, ox_q;
  logic [YW-1:0]     oy_q;
  logic              mode_q, out_valid_q;
  logic [PW-1:0]     out_pixel_q;
  logic [PW-1:0]     lb0_q [IMAGE_LEN];
  logic [PW-1:0]     lb1_q [IMAGE_LEN];
  logic [PW-1:0]     win_q [3][3];
  logic [PW-1:0]     wn    [3][3];
  logic [PW-1:0]     new_pix, med, res;
  logic [9*PIXEL_W-1:0] mv;
  logic              slot_free, adv, emit, border;

  // Rank-select: the element with exactly four predecessors (ties broken by position) is the median.
  function automatic logic [PIXEL_W-1:0] med9(input logic [9*PIXEL_W-1:0] v);
    logic [PIXEL_W-1:0] m;
    int rk;
    m = '0;
    for (int i = 0; i < 9; i++) begin
      rk = 0;
      for (int j = 0; j < 9; j++)
        rk += (v[j*PIXEL_W +: PIXEL_W] < v[i*PIXEL_W +: PIXEL_W] ||
               (v[j*PIXEL_W +: PIXEL_W] == v[i*PIXEL_W +: PIXEL_W] && j < i)) ? 1 : 0;
      if (rk == 4) m = v[i*PIXEL_W +: PIXEL_W];
    end
    return m;
  endfunction

  // Flush keeps shifting zeros through so the centre pixel keeps tracking raster order.
  always_comb begin
    slot_free = !out_valid_q || out_ready_i;
    new_pix   = state_q == FLUSH ? '0 : in_pixel_i;
    adv       = slot_free && (state_q == FLUSH ? cnt_q != CW'(TOT + IMAGE_LEN + 1)
                                               : (state_q == FILL || state_q == RUN) && in_valid_i);
    emit      = adv && cnt_q > CW'(IMAGE_LEN);
    for (int r = 0; r < 3; r++) begin
      wn[r][0] = win_q[r][1];
      wn[r][1] = win_q[r][2];
    end
    wn[0][2] = lb1_q[col_q];
    wn[1][2] = lb0_q[col_q];
    wn[2][2] = new_pix;
    med = '0;
    mv  = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          mv[(r*3+c)*PIXEL_W +: PIXEL_W] = wn[r][c][ch*PIXEL_W +: PIXEL_W];
      med[ch*PIXEL_W +: PIXEL_W] = med9(mv);
    end
    border = oy_q == '0 || oy_q == YW'(IMAGE_HEIGHT - 1) || ox_q == '0 || ox_q == XW'(IMAGE_LEN - 1);
    res    = border ? (mode_q ? '0 : wn[1][1]) : med;
  end

  always_comb begin
    state_d    = state_q;
    in_ready_o = (state_q == FILL || state_q == RUN) && slot_free;
    busy_o     = state_q != IDLE;
    done_o     = state_q == DONE;
    unique case (state_q)
      IDLE:    state_d = start_i ? FILL : IDLE;
      FILL:    state_d = adv && cnt_q == CW'(IMAGE_LEN) ? RUN : FILL;
      RUN:     state_d = adv && cnt_q == CW'(TOT - 1) ? FLUSH : RUN;
      FLUSH:   state_d = cnt_q == CW'(TOT + IMAGE_LEN + 1) && out_valid_q && out_ready_i ? DONE : FLUSH;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      col_q       <= '0;
      ox_q        <= '0;
      oy_q        <= '0;
      mode_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_pixel_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start_i) begin
        cnt_q  <= '0;
        col_q  <= '0;
        ox_q   <= '0;
        oy_q   <= '0;
        mode_q <= border_mode_i;
      end
      if (adv) begin
        cnt_q <= cnt_q + 1'b1;
        col_q <= col_q == XW'(IMAGE_LEN - 1) ? '0 : col_q + 1'b1;
      end
      if (emit) begin
        out_valid_q <= 1'b1;
        out_pixel_q <= res;
        ox_q        <= ox_q == XW'(IMAGE_LEN - 1) ? '0 : ox_q + 1'b1;
        if (ox_q == XW'(IMAGE_LEN - 1)) oy_q <= oy_q == YW'(IMAGE_HEIGHT - 1) ? '0 : oy_q + 1'b1;
      end else if (out_ready_i) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          win_q[r][c] <= wn[r][c];
      lb1_q[col_q] <= lb0_q[col_q];
      lb0_q[col_q] <= new_pix;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_pixel_o = out_pixel_q;
endmodule

// File: tb/tb_median3x3_stream_filter.sv
// tb_median3x3_stream_filter: directed 4x4-frame checks of the 3x3 median stream filter.
module tb_median3x3_stream_filter;
  logic        clk = 1'b0, rst = 1'b1, start_i = 1'b0, border_mode_i = 1'b0;
  logic        in_valid_i = 1'b0, out_ready_i = 1'b0;
  logic [23:0] in_pixel_i = '0;
  logic        in_ready_o, out_valid_o, busy_o, done_o;
  logic [23:0] out_pixel_o;

  int          n_chk = 0, n_pass = 0;
  logic [23:0] fr [16];
  logic [23:0] got [16];
  logic [23:0] ex [16];
  int          n_got, n_done, t_last, t_done, viol;

  median3x3_stream_filter #(.IMAGE_LEN(4), .IMAGE_HEIGHT(4), .PIXEL_W(8), .NUM_CH(3)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .border_mode_i(border_mode_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_pixel_i(in_pixel_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_pixel_o(out_pixel_o),
    .busy_o(busy_o), .done_o(done_o)
  );

  initial forever #5 clk = ~clk;

  // Drives one frame from fr[] and records outputs, done pulses and handshake violations.
  task automatic run_frame(input bit mode, input int pin, input int pout, input bit pulse);
    int idx, cyc;
    bit pstall;
    logic [23:0] ppix;
    idx = 0; cyc = 0; n_got = 0; n_done = 0; t_last = -1; t_done = -1; viol = 0;
    pstall = 1'b0; ppix = '0;
    foreach (got[i]) got[i] = 'x;
    @(negedge clk);
    start_i = 1'b1; border_mode_i = mode; in_valid_i = 1'b0; out_ready_i = 1'b1;
    while (cyc < 3000 && !(n_done > 0 && cyc >= t_done + 3)) begin
      @(negedge clk);
      start_i       = pulse && busy_o;
      border_mode_i = pulse ? ~border_mode_i : mode;
      in_valid_i    = idx < 16 && int'($urandom_range(99)) < pin;
      in_pixel_i    = in_valid_i ? fr[idx] : 24'($urandom);
      out_ready_i   = int'($urandom_range(99)) < pout;
      #1;
      if (pstall && (!out_valid_o || out_pixel_o !== ppix)) viol++;
      if (out_valid_o && !out_ready_i && in_ready_o) viol++;
      pstall = out_valid_o && !out_ready_i;
      ppix   = out_pixel_o;
      if (done_o) begin n_done++; t_done = cyc; end
      if (in_valid_i && in_ready_o) idx++;
      if (out_valid_o && out_ready_i) begin
        if (n_got < 16) got[n_got] = out_pixel_o;
        n_got++;
        t_last = cyc;
      end
      cyc++;
    end
    @(negedge clk);
    start_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
  endtask

  task automatic load_ramp();
    for (int i = 0; i < 16; i++) fr[i] = {8'h77, (i == 5 || i == 10) ? 8'h90 : 8'h30, 8'(i)};
  endtask

  // Interior medians: ch0 ramp gives 5,6,9,10; two spikes cannot move ch1 off 0x30; ch2 constant.
  task automatic build_ramp_expect(input bit mode);
    for (int i = 0; i < 16; i++) begin
      if (i == 5 || i == 6 || i == 9 || i == 10) ex[i] = {8'h77, 8'h30, 8'(i)};
      else ex[i] = mode ? 24'h0 : fr[i];
    end
  endtask

  task automatic test_reset();
    in_valid_i = 1'b1; in_pixel_i = 24'hABCDEF; start_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_chk++; if (out_valid_o !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid_o); else n_pass++;
    n_chk++; if (out_pixel_o !== 24'h0) $display("FAIL reset_out_pixel: got %h expected 000000", out_pixel_o); else n_pass++;
    n_chk++; if (in_ready_o !== 1'b0) $display("FAIL reset_in_ready: got %b expected 0", in_ready_o); else n_pass++;
    n_chk++; if (busy_o !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy_o); else n_pass++;
    n_chk++; if (done_o !== 1'b0) $display("FAIL reset_done: got %b expected 0", done_o); else n_pass++;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    n_chk++; if (in_ready_o !== 1'b0 || busy_o !== 1'b0) $display("FAIL idle_no_accept: got ready=%b busy=%b expected 0 0", in_ready_o, busy_o); else n_pass++;
    @(negedge clk); in_valid_i = 1'b0;
  endtask

  task automatic test_constant();
    for (int i = 0; i < 16; i++) fr[i] = 24'h404040;
    run_frame(1'b0, 100, 100, 1'b0);
    n_chk++; if (n_got !== 16) $display("FAIL const_count: got %0d expected 16", n_got); else n_pass++;
    for (int i = 0; i < 16; i++) begin
      n_chk++; if (got[i] !== 24'h404040) $display("FAIL const_px[%0d]: got %h expected 404040", i, got[i]); else n_pass++;
    end
    n_chk++; if (n_done !== 1) $display("FAIL const_done_count: got %0d expected 1", n_done); else n_pass++;
    n_chk++; if (t_done !== t_last + 1) $display("FAIL const_done_timing: got cycle %0d expected %0d", t_done, t_last + 1); else n_pass++;
    n_chk++; if (busy_o !== 1'b0) $display("FAIL const_busy_after: got %b expected 0", busy_o); else n_pass++;
  endtask

  task automatic test_impulse();
    for (int i = 0; i < 16; i++) fr[i] = (i == 5) ? 24'hFFFFFF : 24'h0;
    run_frame(1'b0, 100, 100, 1'b0);
    n_chk++; if (n_got !== 16) $display("FAIL impulse_count: got %0d expected 16", n_got); else n_pass++;
    for (int i = 0; i < 16; i++) begin
      n_chk++; if (got[i] !== 24'h0) $display("FAIL impulse_px[%0d]: got %h expected 000000", i, got[i]); else n_pass++;
    end
  endtask

  task automatic test_ramp(input bit mode);
    load_ramp();
    build_ramp_expect(mode);
    run_frame(mode, 100, 100, 1'b0);
    n_chk++; if (n_got !== 16) $display("FAIL ramp%0d_count: got %0d expected 16", mode, n_got); else n_pass++;
    for (int i = 0; i < 16; i++) begin
      n_chk++; if (got[i] !== ex[i]) $display("FAIL ramp%0d_px[%0d]: got %h expected %h", mode, i, got[i], ex[i]); else n_pass++;
    end
  endtask

  task automatic test_back_to_back_stall();
    load_ramp();
    build_ramp_expect(1'b0);
    run_frame(1'b0, 70, 50, 1'b0);
    n_chk++; if (n_got !== 16) $display("FAIL stall_count: got %0d expected 16", n_got); else n_pass++;
    for (int i = 0; i < 16; i++) begin
      n_chk++; if (got[i] !== ex[i]) $display("FAIL stall_px[%0d]: got %h expected %h", i, got[i], ex[i]); else n_pass++;
    end
    n_chk++; if (viol !== 0) $display("FAIL stall_handshake: got %0d violations expected 0", viol); else n_pass++;
    n_chk++; if (n_done !== 1) $display("FAIL stall_done_count: got %0d expected 1", n_done); else n_pass++;
  endtask

  task automatic test_abort();
    int acc, cyc, dn;
    @(negedge clk);
    start_i = 1'b1; border_mode_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0; acc = 0; cyc = 0;
    while (acc < 7 && cyc < 100) begin
      in_valid_i = 1'b1; in_pixel_i = 24'h050505;
      #1;
      if (in_ready_o) acc++;
      cyc++;
      @(negedge clk);
    end
    in_valid_i = 1'b0;
    n_chk++; if (acc !== 7) $display("FAIL abort_accept: got %0d expected 7", acc); else n_pass++;
    n_chk++; if (out_valid_o !== 1'b1) $display("FAIL abort_pre_valid: got %b expected 1", out_valid_o); else n_pass++;
    rst = 1'b1;
    @(posedge clk); #1;
    n_chk++; if (out_valid_o !== 1'b0) $display("FAIL abort_out_valid: got %b expected 0", out_valid_o); else n_pass++;
    n_chk++; if (busy_o !== 1'b0) $display("FAIL abort_busy: got %b expected 0", busy_o); else n_pass++;
    @(negedge clk); rst = 1'b0;
    dn = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done_o) dn++;
    end
    n_chk++; if (dn !== 0) $display("FAIL abort_no_done: got %0d expected 0", dn); else n_pass++;
    for (int i = 0; i < 16; i++) fr[i] = 24'h101010;
    run_frame(1'b0, 100, 100, 1'b0);
    n_chk++; if (n_got !== 16) $display("FAIL abort_next_count: got %0d expected 16", n_got); else n_pass++;
    for (int i = 0; i < 16; i++) begin
      n_chk++; if (got[i] !== 24'h101010) $display("FAIL abort_next_px[%0d]: got %h expected 101010", i, got[i]); else n_pass++;
    end
  endtask

  task automatic test_start_ignored();
    load_ramp();
    build_ramp_expect(1'b1);
    run_frame(1'b1, 100, 100, 1'b1);
    n_chk++; if (n_got !== 16) $display("FAIL restart_count: got %0d expected 16", n_got); else n_pass++;
    n_chk++; if (n_done !== 1) $display("FAIL restart_done_count: got %0d expected 1", n_done); else n_pass++;
    for (int i = 0; i < 16; i++) begin
      n_chk++; if (got[i] !== ex[i]) $display("FAIL restart_px[%0d]: got %h expected %h", i, got[i], ex[i]); else n_pass++;
    end
    for (int i = 0; i < 16; i++) fr[i] = 24'h404040;
    run_frame(1'b0, 100, 100, 1'b0);
    n_chk++; if (n_got !== 16) $display("FAIL second_count: got %0d expected 16", n_got); else n_pass++;
    n_chk++; if (got[0] !== 24'h404040 || got[15] !== 24'h404040) $display("FAIL second_px: got %h %h expected 404040 404040", got[0], got[15]); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_constant();
    test_impulse();
    test_ramp(1'b1);
    test_ramp(1'b0);
    test_back_to_back_stall();
    test_abort();
    test_start_ignored();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
